noise_gate_expander: RTL and testbench

Downward expander / noise gate for the pedal's dynamics path. It attenuates signed 16-bit samples whose envelope falls below a threshold and passes loud material at unity gain, so it acts in the opposite direction to the compressor. A peak envelope follower drives an attack/hold/release gain state machine. The block sits between the sample source and the effect chain, with a one-cycle valid-qualified pipeline.

---
 rtl/noise_gate_expander.sv | 164 ++++++++++++++++
 tb/tb_noise_gate_expander.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/noise_gate_expander.sv
// Downward expander / noise gate: a peak envelope follower drives an
// attack/hold/release gain FSM, and a one-cycle valid-qualified gain stage applies the gain.
module noise_gate_expander #(
    parameter int ENV_DECAY_SHIFT = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic signed [15:0] audio_in,
    input  logic [7:0]         threshold,
    input  logic [7:0]         floor_gain,
    input  logic [7:0]         attack_step,
    input  logic [7:0]         release_step,
    input  logic [7:0]         hold_samples,
    output logic signed [15:0] audio_out,
    output logic               out_valid,
    output logic [15:0]        envelope,
    output logic [8:0]         gain,
    output logic [2:0]         gate_state
);

    typedef enum logic [2:0] {
        CLOSED  = 3'd0,
        ATTACK  = 3'd1,
        OPEN    = 3'd2,
        HOLD    = 3'd3,
        RELEASE = 3'd4
    } gate_t;

    localparam logic [8:0] UNITY = 9'd256;

    gate_t       state_q, state_d;
    logic [8:0]  gain_q, gain_d;
    logic [15:0] env_q, env_next;
    logic [7:0]  hold_q, hold_d;

    logic [15:0] neg_in;
    logic [15:0] mag;
    logic [15:0] env_decayed;
    logic [15:0] thr;
    logic        above;

    logic [7:0]  att_inc;
    logic [7:0]  rel_dec;
    logic [9:0]  att_sum;
    logic [8:0]  rel_floored;
    logic [8:0]  rel_res;

    logic signed [25:0] in_ext;
    logic signed [25:0] gain_ext;
    logic signed [25:0] product;
    logic signed [15:0] audio_d;

    // Magnitude: the most negative sample has no positive twin, so clamp it.
    assign neg_in = 16'(~audio_in) + 16'd1;
    always_comb begin
        if (!audio_in[15])
            mag = audio_in;
        else if (neg_in[15])
            mag = 16'h7fff;
        else
            mag = neg_in;
    end

    assign env_decayed = env_q - (env_q >> ENV_DECAY_SHIFT);
    assign env_next    = (mag >= env_q) ? mag : env_decayed;
    assign thr         = {1'b0, threshold, 7'b0};
    assign above       = (env_next >= thr);

    // A zero step would stall the ramp forever, so it behaves as one.
    assign att_inc     = (attack_step  == 8'd0) ? 8'd1 : attack_step;
    assign rel_dec     = (release_step == 8'd0) ? 8'd1 : release_step;
    assign att_sum     = {1'b0, gain_q} + {2'b00, att_inc};
    assign rel_floored = (gain_q < {1'b0, rel_dec}) ? 9'd0 : (gain_q - {1'b0, rel_dec});
    assign rel_res     = (rel_floored < {1'b0, floor_gain}) ? {1'b0, floor_gain} : rel_floored;

    // Gain stage uses the pre-update gain; the shift floors toward -inf, and
    // gain <= 256 keeps the result inside 16 bits.
    assign in_ext   = 26'(audio_in);
    assign gain_ext = 26'($signed({1'b0, gain_q}));
    assign product  = in_ext * gain_ext;
    assign audio_d  = 16'(product >>> 8);

    // NOTE: every output of a combinational block gets a default first so no
    // path through the case leaves it unassigned (which would infer a latch).
    always_comb begin
        state_d = state_q;
        gain_d  = gain_q;
        hold_d  = hold_q;
        case (state_q)
            CLOSED: begin
                gain_d = {1'b0, floor_gain};
                if (above)
                    state_d = ATTACK;
            end
            ATTACK: begin
                if (att_sum >= 10'(UNITY)) begin
                    gain_d  = UNITY;
                    state_d = OPEN;
                end else begin
                    gain_d = att_sum[8:0];
                    if (!above)
                        state_d = RELEASE;
                end
            end
            OPEN: begin
                gain_d = UNITY;
                if (!above) begin
                    if (hold_samples == 8'd0) begin
                        state_d = RELEASE;
                    end else begin
                        state_d = HOLD;
                        hold_d  = hold_samples;
                    end
                end
            end
            HOLD: begin
                if (above)
                    state_d = OPEN;
                else if (hold_q <= 8'd1)
                    state_d = RELEASE;
                else
                    hold_d = hold_q - 8'd1;
            end
            RELEASE: begin
                gain_d = rel_res;
                if (above)
                    state_d = ATTACK;
                else if (rel_res == {1'b0, floor_gain})
                    state_d = CLOSED;
            end
            default: begin
                state_d = CLOSED;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= CLOSED;
            gain_q    <= 9'd0;
            env_q     <= 16'd0;
            hold_q    <= 8'd0;
            audio_out <= 16'sd0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                state_q   <= state_d;
                gain_q    <= gain_d;
                env_q     <= env_next;
                hold_q    <= hold_d;
                audio_out <= audio_d;
            end
        end
    end

    assign envelope   = env_q;
    assign gain       = gain_q;
    assign gate_state = state_q;

endmodule

// File: tb/tb_noise_gate_expander.sv
// Self-checking bench for noise_gate_expander: directed scenarios plus randomized
// traffic, compared against an integer reference model of the gate's rules.
module tb_noise_gate_expander;

    localparam int DECAY_DIV = 16;
    localparam int ST_CLOSED = 0, ST_ATTACK = 1, ST_OPEN = 2, ST_HOLD = 3, ST_RELEASE = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic signed [15:0] audio_in;
    logic [7:0]         threshold, floor_gain, attack_step, release_step, hold_samples;
    logic signed [15:0] audio_out;
    logic               out_valid;
    logic [15:0]        envelope;
    logic [8:0]         gain;
    logic [2:0]         gate_state;

    noise_gate_expander dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .audio_in(audio_in),
        .threshold(threshold), .floor_gain(floor_gain), .attack_step(attack_step),
        .release_step(release_step), .hold_samples(hold_samples),
        .audio_out(audio_out), .out_valid(out_valid), .envelope(envelope),
        .gain(gain), .gate_state(gate_state)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    int m_env, m_gain, m_state, m_hold, m_out, m_ov;

    task automatic check(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_env = 0; m_gain = 0; m_state = ST_CLOSED; m_hold = 0; m_out = 0; m_ov = 0;
    endtask

    task automatic model_sample(input int s);
        int mag, envn, thr, step, sum, res;
        bit above;
        mag   = (s < 0) ? -s : s;
        if (mag > 32767) mag = 32767;
        envn  = (mag >= m_env) ? mag : m_env - m_env / DECAY_DIV;
        thr   = int'(threshold) * 128;
        above = (envn >= thr);
        m_out = (s * m_gain) >>> 8;
        case (m_state)
            ST_CLOSED: begin
                m_gain = floor_gain;
                if (above) m_state = ST_ATTACK;
            end
            ST_ATTACK: begin
                step = (attack_step == 0) ? 1 : int'(attack_step);
                sum  = m_gain + step;
                if (sum >= 256) begin
                    m_gain = 256; m_state = ST_OPEN;
                end else begin
                    m_gain = sum;
                    if (!above) m_state = ST_RELEASE;
                end
            end
            ST_OPEN: begin
                m_gain = 256;
                if (!above) begin
                    if (hold_samples == 0) m_state = ST_RELEASE;
                    else begin m_state = ST_HOLD; m_hold = hold_samples; end
                end
            end
            ST_HOLD: begin
                if (above) m_state = ST_OPEN;
                else if (m_hold <= 1) m_state = ST_RELEASE;
                else m_hold--;
            end
            default: begin
                step = (release_step == 0) ? 1 : int'(release_step);
                res  = m_gain - step;
                if (res < 0) res = 0;
                if (res < int'(floor_gain)) res = floor_gain;
                m_gain = res;
                if (above) m_state = ST_ATTACK;
                else if (res == int'(floor_gain)) m_state = ST_CLOSED;
            end
        endcase
        m_env = envn;
        m_ov  = 1;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".audio_out"},  audio_out,  m_out);
        check({tag, ".out_valid"},  out_valid,  m_ov);
        check({tag, ".envelope"},   envelope,   m_env);
        check({tag, ".gain"},       gain,       m_gain);
        check({tag, ".gate_state"}, gate_state, m_state);
    endtask

    // One clock: present inputs, take the edge, compare 1 time unit later.
    task automatic step(input bit v, input int s, input string tag);
        in_valid = v;
        audio_in = 16'(s);
        @(posedge clk);
        #1;
        if (v) model_sample(s);
        else   m_ov = 0;
        check_all(tag);
    endtask

    int exp_out[6]  = '{0, 0, 1024, 2048, 3072, 4096};
    int exp_gain[6] = '{0, 64, 128, 192, 256, 256};

    initial begin
        int n_hold, guard, amp, s;

        rst = 1'b1; in_valid = 1'b0; audio_in = '0;
        threshold = 8'h10; floor_gain = 8'd0; attack_step = 8'd64;
        release_step = 8'd128; hold_samples = 8'd3;
        model_reset();

        // Reset holds everything at zero even with in_valid toggling.
        for (int i = 0; i < 4; i++) begin
            in_valid = i[0];
            audio_in = 16'sd1234;
            @(posedge clk);
            #1;
            check_all("reset");
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) step(1'b0, 4321, "idle");

        // Closed mute.
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1000, "mute");
            check("mute.out_const", audio_out, 0);
        end
        check("mute.env_const", envelope, 1000);
        check("mute.state_const", gate_state, ST_CLOSED);

        // Attack ramp.
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 4096, "attack");
            check("attack.out_const", audio_out, exp_out[i]);
            check("attack.gain_const", gain, exp_gain[i]);
        end
        check("attack.open", gate_state, ST_OPEN);

        // Hold then release down to CLOSED.
        n_hold = 0;
        guard  = 0;
        while (m_state != ST_CLOSED && guard < 100) begin
            step(1'b1, 0, "release");
            if (gate_state == 3'(ST_HOLD)) n_hold++;
            guard++;
        end
        check("release.reached_closed", gate_state, ST_CLOSED);
        check("hold.length", n_hold, 3);

        // Retrigger while in HOLD.
        guard = 0;
        while (m_state != ST_OPEN && guard < 20) begin step(1'b1, 4096, "reopen"); guard++; end
        guard = 0;
        while (m_state != ST_HOLD && guard < 100) begin step(1'b1, 0, "to_hold"); guard++; end
        check("retrig.in_hold", gate_state, ST_HOLD);
        step(1'b1, -8192, "retrig");
        check("retrig.state", gate_state, ST_OPEN);
        check("retrig.env", envelope, 8192);
        check("retrig.out", audio_out, -8192);

        // Most negative sample at unity gain.
        step(1'b1, -32768, "minval");
        check("minval.env", envelope, 32767);
        check("minval.out", audio_out, -32768);

        // hold_samples = 0: OPEN goes straight to RELEASE.
        hold_samples = 8'd0;
        guard = 0;
        while (m_state == ST_OPEN && guard < 200) begin step(1'b1, 0, "nohold"); guard++; end
        check("nohold.state", gate_state, ST_RELEASE);
        guard = 0;
        while (m_state != ST_CLOSED && guard < 20) begin step(1'b1, 0, "nohold_rel"); guard++; end
        check("nohold.closed", gate_state, ST_CLOSED);

        // attack_step = 0 ramps by one per sample.
        attack_step = 8'd0;
        step(1'b1, 4096, "atk0");
        check("atk0.gain0", gain, 0);
        for (int i = 1; i <= 3; i++) begin
            step(1'b1, 4096, "atk0");
            check("atk0.gain_inc", gain, i);
        end

        // Randomized traffic with back-to-back valids, gaps and config changes.
        amp = 1;
        for (int i = 0; i < 3000; i++) begin
            if (i % 40 == 0) amp = $urandom_range(0, 3);
            if ($urandom_range(0, 49) == 0) begin
                threshold    = 8'($urandom_range(0, 60));
                floor_gain   = 8'($urandom_range(0, 255));
                attack_step  = 8'($urandom_range(0, 80));
                release_step = 8'($urandom_range(0, 80));
                hold_samples = 8'($urandom_range(0, 6));
            end
            case (amp)
                0: s = int'($urandom_range(0, 600)) - 300;
                1: s = int'($urandom_range(0, 16000)) - 8000;
                2: s = int'($urandom_range(0, 65535)) - 32768;
                default: s = ($urandom_range(0, 3) == 0) ? -32768 : int'($urandom_range(0, 200));
            endcase
            step($urandom_range(0, 4) != 0, s, "rand");

            if (i == 1700) begin
                // Asynchronous reset between edges drops state and in-flight out_valid.
                in_valid = 1'b1;
                audio_in = 16'sd5000;
                #2 rst = 1'b1;
                #1;
                model_reset();
                check_all("midreset");
                #3 rst = 1'b0;
                in_valid = 1'b0;
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
